// File: rtl/usb11_tx_sched.sv
// Transmit scheduler for the low-speed USB send engine: arbitrates two requesters,
// streams buffer bytes to the engine, guards the frame end. Option: USB11_SCHED_RR_EN.
module usb11_tx_sched #(
   parameter int FRAME_CLKS = 12000,
   parameter int LATE_CLKS  = 1200,
   parameter int WD_CLKS    = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   output logic       rd_sel,
   output logic [2:0] rd_idx,
   input  logic [7:0] rd_data0,
   input  logic [7:0] rd_data1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic [1:0] err,
   output logic       busy,
   output logic [7:0] sbyte,
   output logic       start_pkt,
   output logic       last_pkt_byte,
   input  logic       show_next,
   input  logic       pkt_end,
   input  logic       eop
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ARB      = 3'd1;
   localparam logic [2:0] FETCH    = 3'd2;
   localparam logic [2:0] START    = 3'd3;
   localparam logic [2:0] SEND     = 3'd4;
   localparam logic [2:0] WAIT_END = 3'd5;

   logic [2:0]  state;
   logic [13:0] frame_cnt;
   logic        eop_q;
   logic [3:0]  len_q;
   logic        pend;
   logic [10:0] wd_cnt;
   logic        win_nxt;
   logic [3:0]  len_sel;
   logic [7:0]  rd_data;
   logic        eop_rise;
   logic        can_start;
   logic        at_last;

`ifdef USB11_SCHED_RR_EN
   logic rr_last;
   assign win_nxt = (req == 2'b11) ? ~rr_last : ~req[0];

   // Pointer only matters back in IDLE, so recording the winner at grant time
   // is equivalent to recording it when the transaction ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_last <= 1'b1;
      else if (state == IDLE && can_start)
         rr_last <= win_nxt;
   end
`else
   assign win_nxt = ~req[0];
`endif

   assign len_sel   = win_nxt ? len1 : len0;
   assign rd_data   = rd_sel ? rd_data1 : rd_data0;
   assign eop_rise  = eop & ~eop_q;
   assign can_start = (|req) && !eop && (frame_cnt < 14'(FRAME_CLKS - LATE_CLKS));
   assign at_last   = ({1'b0, rd_idx} == (len_q - 4'd1));
   assign busy      = (state != IDLE);
   // pend masks the one clock where rd_idx has advanced but sbyte still holds the prior byte
   assign last_pkt_byte = at_last && !pend &&
                          (state == START || state == SEND || state == WAIT_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_cnt <= '0;
         eop_q     <= 1'b0;
         len_q     <= '0;
         pend      <= 1'b0;
         wd_cnt    <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= '0;
         sbyte     <= '0;
         start_pkt <= 1'b0;
         rd_sel    <= 1'b0;
         rd_idx    <= '0;
      end else begin
         eop_q <= eop;
         if (eop_q && !eop)
            frame_cnt <= '0;
         else if (frame_cnt != 14'(FRAME_CLKS - 1))
            frame_cnt <= frame_cnt + 14'd1;
         done      <= '0;
         err       <= '0;
         start_pkt <= 1'b0;
         case (state)
            IDLE: if (can_start) begin
               state  <= ARB;
               gnt    <= win_nxt ? 2'b10 : 2'b01;
               rd_sel <= win_nxt;
               rd_idx <= '0;
               len_q  <= len_sel;
               pend   <= 1'b0;
            end
            ARB: if (len_q == 4'd0 || len_q > 4'd8) begin
               err   <= gnt;
               gnt   <= '0;
               state <= IDLE;
            end else
               state <= FETCH;
            FETCH: if (eop) begin
               err   <= gnt;
               gnt   <= '0;
               state <= IDLE;
            end else begin
               sbyte     <= rd_data;
               start_pkt <= 1'b1;
               state     <= START;
            end
            START: state <= SEND;
            SEND: if (eop_rise) begin
               err   <= gnt;
               gnt   <= '0;
               state <= IDLE;
            end else if (pend) begin
               sbyte <= rd_data;
               pend  <= 1'b0;
            end else if (at_last) begin
               state  <= WAIT_END;
               wd_cnt <= '0;
            end else if (show_next) begin
               rd_idx <= rd_idx + 3'd1;
               pend   <= 1'b1;
            end
            WAIT_END: if (pkt_end) begin
               done  <= gnt;
               gnt   <= '0;
               state <= IDLE;
            end else if (eop_rise || wd_cnt == 11'(WD_CLKS - 1)) begin
               err   <= gnt;
               gnt   <= '0;
               state <= IDLE;
            end else
               wd_cnt <= wd_cnt + 11'd1;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb11_tx_sched.sv
// Bench for usb11_tx_sched: acts as requesters, buffers and send engine; expected
// bytes are queued when a request is raised and checked as the DUT presents them.
`timescale 1ns/1ps
module tb_usb11_tx_sched;

   localparam int FRAME_CLKS = 12000;
   localparam int LATE_CLKS  = 1200;
   localparam int WD_CLKS    = 1024;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req;
   logic [3:0] len0, len1;
   logic       rd_sel;
   logic [2:0] rd_idx;
   logic [7:0] rd_data0, rd_data1;
   logic [1:0] gnt, done, err;
   logic       busy;
   logic [7:0] sbyte;
   logic       start_pkt, last_pkt_byte;
   logic       show_next, pkt_end, eop;

   logic [7:0] mem0 [0:7];
   logic [7:0] mem1 [0:7];
   logic [8:0] exp_q [$];

   int tests = 0;
   int fails = 0;
   int starts = 0;
   int tb_fc = 0;
   int start_fc = -1;

   always #5 clk = ~clk;

   assign rd_data0 = mem0[rd_idx];
   assign rd_data1 = mem1[rd_idx];

   usb11_tx_sched #(.FRAME_CLKS(FRAME_CLKS), .LATE_CLKS(LATE_CLKS), .WD_CLKS(WD_CLKS)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1),
      .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_data0(rd_data0), .rd_data1(rd_data1),
      .gnt(gnt), .done(done), .err(err), .busy(busy), .sbyte(sbyte),
      .start_pkt(start_pkt), .last_pkt_byte(last_pkt_byte),
      .show_next(show_next), .pkt_end(pkt_end), .eop(eop)
   );

   // Reference frame counter: clears after eop falls, else counts and saturates.
   logic eop_d;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tb_fc <= 0;
         eop_d <= 1'b0;
      end else begin
         eop_d <= eop;
         if (eop_d && !eop) tb_fc <= 0;
         else if (tb_fc < FRAME_CLKS - 1) tb_fc <= tb_fc + 1;
      end
   end

   always @(negedge clk) if (start_pkt === 1'b1) starts++;

   initial begin
      #2ms;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // mode: 0 normal end, 1 eop abort after 3 bytes, 2 watchdog, 3 pkt_end with eop rise
   task automatic run_pkt(input int r, input int n, input int lat, input int mode, input bit drop);
      int cnt;
      bit seen, sawdone;
      logic [8:0] e;
      logic [1:0] g;
      g = 2'b01 << r;
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == n - 1), (r != 0) ? mem1[i] : mem0[i]});
      cnt = 0; seen = 0;
      while (!seen && cnt < 50) begin
         @(negedge clk); cnt++;
         if (cnt == 1 && lat != 0) begin
            tests++;
            if (gnt !== g) begin $display("FAIL gnt_plus1 got %b want %b", gnt, g); fails++; end
         end
         seen = (start_pkt === 1'b1);
      end
      tests++;
      if (!seen) begin
         $display("FAIL start_timeout got none want start_pkt for req%0d", r);
         fails++; exp_q.delete(); req[r] = 1'b0; return;
      end
      start_fc = tb_fc;
      if (lat != 0) begin
         tests++;
         if (cnt !== lat) begin $display("FAIL start_latency got %0d want %0d", cnt, lat); fails++; end
      end
      tests++;
      if (gnt !== g) begin $display("FAIL gnt_at_start got %b want %b", gnt, g); fails++; end
      e = exp_q.pop_front();
      tests++;
      if ({last_pkt_byte, sbyte} !== e) begin
         $display("FAIL byte0 got %h want %h", {last_pkt_byte, sbyte}, e); fails++;
      end
      for (int i = 1; i < n; i++) begin
         if (mode == 1 && i == 3) break;
         repeat (4) @(negedge clk);
         show_next = 1'b1; @(negedge clk); show_next = 1'b0; @(negedge clk);
         e = exp_q.pop_front();
         tests++;
         if ({last_pkt_byte, sbyte} !== e) begin
            $display("FAIL byte%0d got %h want %h", i, {last_pkt_byte, sbyte}, e); fails++;
         end
      end
      if (mode == 0 || mode == 3) begin
         show_next = 1'b1; @(negedge clk); show_next = 1'b0; @(negedge clk);
         tests++;
         if ({rd_idx, last_pkt_byte, sbyte} !== {3'(n - 1), e}) begin
            $display("FAIL extra_show_next got idx %0d %h want idx %0d %h",
                     rd_idx, {last_pkt_byte, sbyte}, n - 1, e); fails++;
         end
         repeat (3) @(negedge clk);
         pkt_end = 1'b1; if (mode == 3) eop = 1'b1;
         @(negedge clk);
         pkt_end = 1'b0; eop = 1'b0;
         tests++;
         if ({done, err, gnt, busy} !== {g, 2'b00, 2'b00, 1'b0}) begin
            $display("FAIL done_pulse got done %b err %b gnt %b busy %b want done %b",
                     done, err, gnt, busy, g); fails++;
         end
      end else if (mode == 1) begin
         eop = 1'b1; @(negedge clk);
         tests++;
         if ({err, gnt, busy} !== {g, 2'b00, 1'b0}) begin
            $display("FAIL eop_abort got err %b gnt %b busy %b want err %b", err, gnt, busy, g);
            fails++;
         end
         eop = 1'b0; exp_q.delete();
      end else begin
         cnt = 0; seen = 0; sawdone = 0;
         while (!seen && cnt < WD_CLKS + 50) begin
            @(negedge clk); cnt++;
            seen = (err === g);
            if (done !== 2'b00) sawdone = 1;
         end
         tests++;
         if (!seen || sawdone || cnt < WD_CLKS - 4 || cnt > WD_CLKS + 8 || gnt !== 2'b00) begin
            $display("FAIL watchdog got seen %0d after %0d clks done %0d gnt %b want err near %0d",
                     seen, cnt, sawdone, gnt, WD_CLKS); fails++;
         end
      end
      if (drop) req[r] = 1'b0;
   endtask

   task automatic frame_sync();
      eop = 1'b1; repeat (3) @(negedge clk);
      eop = 1'b0; repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      tests++;
      if ({gnt, done, err, busy, sbyte, start_pkt, last_pkt_byte, rd_sel, rd_idx} !== '0) begin
         $display("FAIL reset_values got gnt %b done %b err %b busy %b sbyte %h sp %b last %b sel %b idx %0d want 0",
                  gnt, done, err, busy, sbyte, start_pkt, last_pkt_byte, rd_sel, rd_idx); fails++;
      end
   endtask

   task automatic test_basic();
      mem0[0] = 8'h80; mem0[1] = 8'h2D; mem0[2] = 8'h00; len0 = 4'd3;
      for (int k = 0; k < 500 && tb_fc < 100; k++) @(negedge clk);
      req[0] = 1'b1;
      run_pkt(0, 3, 3, 0, 1);
   endtask

   task automatic test_back_to_back();
      frame_sync();
      for (int i = 0; i < 8; i++) begin mem0[i] = 8'h10 + 8'(i); mem1[i] = 8'hC0 + 8'(i); end
      len0 = 4'd2; len1 = 4'd2;
      req = 2'b11;
`ifdef USB11_SCHED_RR_EN
      run_pkt(0, 2, 3, 0, 0);
      run_pkt(1, 2, 3, 0, 1);
      run_pkt(0, 2, 3, 0, 1);
`else
      run_pkt(0, 2, 3, 0, 0);
      run_pkt(0, 2, 3, 0, 1);
      run_pkt(1, 2, 3, 0, 1);
`endif
   endtask

   task automatic test_len1();
      mem1[0] = 8'hA5; len1 = 4'd1;
      repeat (2) @(negedge clk);
      req[1] = 1'b1;
      run_pkt(1, 1, 3, 0, 1);
   endtask

   task automatic test_bad_len();
      logic [3:0] bad [0:1];
      int s0;
      bad[0] = 4'd0; bad[1] = 4'd9;
      for (int b = 0; b < 2; b++) begin
         len0 = bad[b]; s0 = starts;
         repeat (2) @(negedge clk);
         req[0] = 1'b1;
         @(negedge clk);
         @(negedge clk);
         tests++;
         if ({err, gnt} !== {2'b01, 2'b00}) begin
            $display("FAIL bad_len%0d got err %b gnt %b want err 01", bad[b], err, gnt); fails++;
         end
         req[0] = 1'b0;
         repeat (6) @(negedge clk);
         tests++;
         if (starts !== s0) begin
            $display("FAIL bad_len%0d_start got %0d starts want 0", bad[b], starts - s0); fails++;
         end
      end
   endtask

   task automatic test_eop_abort();
      frame_sync();
      for (int i = 0; i < 8; i++) mem0[i] = 8'h31 * 8'(i + 1);
      len0 = 4'd8;
      req[0] = 1'b1;
      run_pkt(0, 8, 3, 1, 1);
      repeat (3) @(negedge clk);
      req[0] = 1'b1;
      run_pkt(0, 8, 3, 2, 1);
      len0 = 4'd2;
      repeat (3) @(negedge clk);
      req[0] = 1'b1;
      run_pkt(0, 2, 3, 3, 1);
   endtask

   task automatic test_mid_reset();
      int cnt, s0;
      frame_sync();
      len0 = 4'd8;
      req[0] = 1'b1;
      cnt = 0;
      while (start_pkt !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
      repeat (3) @(negedge clk);
      show_next = 1'b1; @(negedge clk); show_next = 1'b0; @(negedge clk);
      rst_n = 1'b0; req = 2'b00;
      #1;
      test_reset();
      s0 = starts;
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(negedge clk);
      tests++;
      if (starts !== s0 || busy !== 1'b0) begin
         $display("FAIL mid_reset_restart got %0d starts busy %b want 0", starts - s0, busy); fails++;
      end
   endtask

   task automatic test_late_window();
      int s0;
      bit bz;
      frame_sync();
      mem0[0] = 8'h5A; mem0[1] = 8'hE1; len0 = 4'd2;
      for (int k = 0; k < 12000 && tb_fc < FRAME_CLKS - LATE_CLKS; k++) @(negedge clk);
      req[0] = 1'b1; s0 = starts; bz = 0;
      repeat (1300) @(negedge clk) if (busy) bz = 1;
      eop = 1'b1;
      repeat (4) @(negedge clk) if (busy) bz = 1;
      tests++;
      if (starts !== s0 || bz) begin
         $display("FAIL late_no_start got %0d starts busy_seen %0d want 0", starts - s0, bz); fails++;
      end
      eop = 1'b0; start_fc = -1;
      run_pkt(0, 2, 0, 0, 1);
      tests++;
      if (start_fc < 0 || start_fc > 3) begin
         $display("FAIL late_start_fc got %0d want 0..3", start_fc); fails++;
      end
   endtask

   initial begin
      rst_n = 1'b0; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
      show_next = 1'b0; pkt_end = 1'b0; eop = 1'b0;
      for (int i = 0; i < 8; i++) begin mem0[i] = '0; mem1[i] = '0; end
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_len1();
      test_bad_len();
      test_eop_abort();
      test_mid_reset();
      test_late_window();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usb11_tx_sched.md
# usb11_tx_sched

Transmit scheduler placed in front of the low-speed USB send engine. It arbitrates between two packet requesters and fetches each packet's bytes from the winning requester's buffer. It drives the engine's byte, start and last-byte inputs, and reports completion or abort per requester. It also refuses to start packets too close to the frame-end keep-alive window.

## Interface
- FRAME_CLKS, 12000: clocks per 1 ms frame (1500 low-speed bit times × 8 clocks).
- LATE_CLKS, 1200: no packet start once frame_cnt ≥ FRAME_CLKS − LATE_CLKS.
- WD_CLKS, 1024: watchdog, max clocks in WAIT_END before abort.
- clk  in  1  12 MHz clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester packet request; held high until matching done/err.
- len0, len1  in  4 each  packet length in bytes for requester 0/1. Legal range 1..8.
- rd_sel  out  1  selected requester buffer.
- rd_idx  out  3  byte index into the selected buffer.
- rd_data0, rd_data1  in  8 each  buffer read data, valid one clock after rd_idx/rd_sel change.
- gnt  out  2  one-hot, high for the whole transaction of the granted requester.
- done  out  2  one-clock pulse: packet sent completely.
- err  out  2  one-clock pulse: packet rejected or aborted.
- busy  out  1  high in any state except IDLE.
- sbyte  out  8  byte to the send engine.
- start_pkt  out  1  one-clock pulse starting the engine.
- last_pkt_byte  out  1  high while sbyte holds the final byte.
- show_next  in  1  engine request for the next byte (one-clock pulse).
- pkt_end  in  1  engine packet-complete pulse.
- eop  in  1  engine frame-end window indicator.

## Operation
- Reset values: gnt=0, done=0, err=0, busy=0, sbyte=0, start_pkt=0, last_pkt_byte=0, rd_sel=0, rd_idx=0, frame_cnt=0, state IDLE.
- frame_cnt is 14-bit. It clears on the clock after eop falls. Otherwise it increments and saturates at FRAME_CLKS−1.
- States:
  - IDLE → ARB when any req bit is high, eop=0 and frame_cnt < FRAME_CLKS−LATE_CLKS.
  - ARB: pick the winner, set gnt, rd_sel=winner, rd_idx=0, latch len. If len=0 or len>8: pulse err[winner] and go to IDLE. Otherwise go to FETCH.
  - FETCH (1 clock): sbyte ← rd_data[rd_sel] → START.
  - START: pulse start_pkt → SEND.
  - SEND:
    - On show_next with rd_idx < len−1: increment rd_idx. sbyte ← rd_data on the next clock.
    - On show_next with rd_idx = len−1: ignore it (the engine can request once more during the last byte).
    - When the last byte has been handed over → WAIT_END.
  - WAIT_END:
    - pkt_end → pulse done[winner], clear gnt → IDLE.
    - A rising edge of eop in SEND or WAIT_END, or watchdog expiry, → pulse err[winner], clear gnt → IDLE.
- last_pkt_byte = (rd_idx == len−1) while in START/SEND/WAIT_END; otherwise 0.
- Fixed priority: requester 0 beats requester 1.
- A req drop during a transaction is ignored. The transaction completes or aborts normally.

## Timing
- req high in IDLE → gnt at +1 clock, start_pkt at +3 clocks (ARB, FETCH, START).
- show_next → new sbyte stable at +2 clocks. The engine loads it about 48 clocks later.
- done/err occur 1 clock after pkt_end or abort cause. The next ARB can be entered on the following clock.
- A start is never issued while eop=1 or within LATE_CLKS of the frame end.
- Simultaneous pkt_end and eop rise: pkt_end wins, done is pulsed.
- rst_n low mid-packet: all outputs go to reset values immediately. The engine receives no further start_pkt.

## Configuration
- USB11_SCHED_RR_EN defined: round-robin arbitration. The requester that did not win the last grant is preferred when both request. The pointer updates on done or err.
- USB11_SCHED_RR_EN undefined: fixed priority, requester 0 always wins.

## Test plan
- len0=3, bytes 0x80,0x2D,0x00, req0 at frame_cnt=100:
  - start_pkt at +3 clocks, sbyte sequence 0x80→0x2D→0x00;
  - last_pkt_byte only with 0x00; done[0] one clock after pkt_end.
- Both req high, fixed priority:
  - two back-to-back transactions, requester 0 granted first both times when req0 is re-raised.
  - With USB11_SCHED_RR_EN, requester 1 is granted second.
- len1=1: last_pkt_byte=1 at start_pkt; show_next during that byte is ignored and rd_idx stays 0.
- len0=0 or 9: err[0] pulses at ARB+1, start_pkt never asserted.
- req0 at frame_cnt=FRAME_CLKS−LATE_CLKS: no start until after the next eop fall; start occurs with frame_cnt≤3.
- eop rising during an 8-byte send: err[0] pulse, gnt cleared, busy=0 on the next clock. Repeat with no pkt_end for WD_CLKS clocks → err[0].
